alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
Parametrised sequential successor to the combinational ALU control decoder. It accepts ALUOp/funct plus operands over a valid/ready handshake, decodes them to a 4-bit ALU control code, and executes the operation. Single-cycle ops complete in one cycle; variable shifts and multiply run iteratively. It sits in the EX stage and stalls the pipeline via ready_o/valid_o.

Parameters:
DATA_W, 32, operand/result width; must be even and >= 32
SH_W, 5, shift-amount width; equals log2(DATA_W)
FUNCT_W, 6, funct field width
OP_W, 3, ALUOp width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous flush; drops any in-flight op
valid_i  in  1  op/operands valid
ready_o  out  1  unit can accept an op
ALUOp_i  in  OP_W  0 R_TYPE, 1 ADDI, 2 SLTIU, 3 BEQ, 4 LUI, 5 ORI, 6 BNE
funct_i  in  FUNCT_W  R-type function field
shamt_i  in  SH_W  constant shift amount
src1_i  in  DATA_W  operand 1 (rs)
src2_i  in  DATA_W  operand 2 (rt/immediate)
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
result_o  out  DATA_W  result
zero_o  out  1  result_o == 0
ALUCtrl_o  out  4  decoded control code of the op held in result_o
illegal_o  out  1  held op was undecodable

Behaviour:
- Control codes: AND 0, OR 1, NAND 2, NOR 3, ADDU 4, SUBU 5, SLT 6, EQUAL 7, SFT 8, SFTV 9, SLTU 10, LUI 11, MUL 12, ILL 15.
- R_TYPE funct decode: 100001 ADDU, 100011 SUBU, 100100 AND, 100101 OR, 101010 SLT, 000011 SFT, 000111 SFTV, 011000 MUL. Any other funct is ILL.
- ALUOp decode: ADDI to ADDU; SLTIU to SLTU; BEQ and BNE to SUBU; LUI to LUI; ORI to OR; ALUOp 7 to ILL.
- Arithmetic: ADDU/SUBU wrap modulo 2^DATA_W. SLT compares signed, SLTU unsigned; result is 1 or 0, zero-extended. LUI yields src2_i[DATA_W/2-1:0] placed in the upper half, lower half 0. MUL yields the low DATA_W bits of the unsigned product.
- Shifts: SFT and SFTV are arithmetic right shifts of src2_i. SFT uses shamt_i; SFTV uses src1_i[SH_W-1:0].
- ILL: result 0, illegal_o=1, 1-cycle completion.
- Reset (rst_i low, asynchronous): state IDLE; ready_o=1 once released; valid_o, result_o, zero_o, ALUCtrl_o and illegal_o all 0; shift and multiply counters 0. Reset mid-operation aborts with no output.
- FSM states: IDLE, SHIFT, MUL, DONE. ready_o = (state==IDLE && !flush_i).
- IDLE: on valid_i && ready_o, latch the operands and decoded code.
  - Single-cycle op, SFT/SFTV with amount 0, or ILL: compute and go to DONE.
  - SFT/SFTV with amount > 0: go to SHIFT, count = amount.
  - MUL: go to MUL, count = DATA_W.
- SHIFT: shift 1 bit per cycle and decrement; when count reaches 1, go to DONE.
- MUL: shift-add one multiplier bit per cycle; after DATA_W cycles, go to DONE.
- Latency from the accept edge to valid_o high:
  - single-cycle op: 1 cycle
  - shift by n: 1+n cycles
  - MUL: DATA_W+1 cycles
- DONE: valid_o=1 and result_o, zero_o, ALUCtrl_o and illegal_o are held stable until the cycle ready_i=1, then return to IDLE. No accept occurs in DONE, so minimum initiation interval is 2 cycles.
- Outputs change only on the DONE entry edge; when valid_o=0 they hold their last values.
- flush_i has priority over all other inputs: the next state is IDLE and valid_o is 0 on the next cycle. A flush in IDLE with valid_i=1 does not accept. A flush in DONE discards the result even if ready_i=1.
- Inputs other than handshake and flush are ignored outside IDLE.

Test Plan:
- Reset, then ADDU (R_TYPE, funct 100001) with src1=5, src2=7 -> one cycle after accept: valid_o=1, result_o=12, ALUCtrl_o=4, zero_o=0.
- BEQ with 9,9, then SUBU with 3,5 -> first result 0 with zero_o=1 and ALUCtrl_o=5; second result 0xFFFFFFFE.
- SFTV with src1=4, src2=0x80000000, then SFT with shamt=0 -> first: valid_o 5 cycles after accept, result 0xF8000000. Second: result=src2 after 1 cycle.
- MUL 0x1234 x 0x10 with ready_i held low 3 cycles after valid_o -> valid_o at cycle 33, result 0x12340 held stable and ready_o=0 until ready_i=1, then IDLE.
- flush_i asserted 10 cycles into a MUL; rst_i pulsed low mid-SHIFT -> valid_o never rises for either op, ready_o=1 next cycle, a following ADDI 1+1 returns 2.
- R_TYPE funct 111111 and ALUOp 7 -> each completes in 1 cycle with illegal_o=1, ALUCtrl_o=15, result 0.

Source files
------------

// File: rtl/alu_exec_seq.sv
// Sequential EX-stage ALU: decodes ALUOp/funct into a 4-bit control code and executes it.
// Logical/arithmetic ops finish in one cycle; variable shifts and multiply iterate.
module alu_exec_seq #(
   parameter int DATA_W  = 32,
   parameter int SH_W    = 5,
   parameter int FUNCT_W = 6,
   parameter int OP_W    = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [OP_W-1:0]    ALUOp_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic [SH_W-1:0]    shamt_i,
   input  logic [DATA_W-1:0]  src1_i,
   input  logic [DATA_W-1:0]  src2_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [DATA_W-1:0]  result_o,
   output logic               zero_o,
   output logic [3:0]         ALUCtrl_o,
   output logic               illegal_o,
   output logic [1:0]         state_o
);

   // Handshake: an op transfers on a rising edge where valid_i && ready_o; a result
   // transfers on a rising edge where valid_o && ready_i. flush_i overrides both.

   localparam int CNT_W = SH_W + 1;
   localparam int HALF  = DATA_W / 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_MUL   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] CTL_AND   = 4'd0;
   localparam logic [3:0] CTL_OR    = 4'd1;
   localparam logic [3:0] CTL_NAND  = 4'd2;
   localparam logic [3:0] CTL_NOR   = 4'd3;
   localparam logic [3:0] CTL_ADDU  = 4'd4;
   localparam logic [3:0] CTL_SUBU  = 4'd5;
   localparam logic [3:0] CTL_SLT   = 4'd6;
   localparam logic [3:0] CTL_EQUAL = 4'd7;
   localparam logic [3:0] CTL_SFT   = 4'd8;
   localparam logic [3:0] CTL_SFTV  = 4'd9;
   localparam logic [3:0] CTL_SLTU  = 4'd10;
   localparam logic [3:0] CTL_LUI   = 4'd11;
   localparam logic [3:0] CTL_MUL   = 4'd12;
   localparam logic [3:0] CTL_ILL   = 4'd15;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(2);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_LUI   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);

   localparam logic [FUNCT_W-1:0] F_ADDU = FUNCT_W'(6'b100001);
   localparam logic [FUNCT_W-1:0] F_SUBU = FUNCT_W'(6'b100011);
   localparam logic [FUNCT_W-1:0] F_AND  = FUNCT_W'(6'b100100);
   localparam logic [FUNCT_W-1:0] F_OR   = FUNCT_W'(6'b100101);
   localparam logic [FUNCT_W-1:0] F_SLT  = FUNCT_W'(6'b101010);
   localparam logic [FUNCT_W-1:0] F_SFT  = FUNCT_W'(6'b000011);
   localparam logic [FUNCT_W-1:0] F_SFTV = FUNCT_W'(6'b000111);
   localparam logic [FUNCT_W-1:0] F_MUL  = FUNCT_W'(6'b011000);

   logic [1:0]        state_q;
   logic [3:0]        ctrl_q;
   logic [DATA_W-1:0] opa_q;
   logic [DATA_W-1:0] opb_q;
   logic [DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]  count_q;

   logic [3:0]        dec_ctrl;
   logic [SH_W-1:0]   dec_amt;
   logic              dec_is_shift;
   logic              dec_multi;
   logic [DATA_W-1:0] quick_res;
   logic [DATA_W-1:0] sh_next;
   logic [DATA_W-1:0] mul_acc_next;
   logic              fin_load;
   logic [DATA_W-1:0] fin_res;
   logic [3:0]        fin_ctrl;

   assign ready_o = (state_q == ST_IDLE) && !flush_i;
   assign valid_o = (state_q == ST_DONE);
   assign state_o = state_q;

   always_comb begin
      dec_ctrl = CTL_ILL;
      case (ALUOp_i)
         OP_RTYPE: begin
            case (funct_i)
               F_ADDU:  dec_ctrl = CTL_ADDU;
               F_SUBU:  dec_ctrl = CTL_SUBU;
               F_AND:   dec_ctrl = CTL_AND;
               F_OR:    dec_ctrl = CTL_OR;
               F_SLT:   dec_ctrl = CTL_SLT;
               F_SFT:   dec_ctrl = CTL_SFT;
               F_SFTV:  dec_ctrl = CTL_SFTV;
               F_MUL:   dec_ctrl = CTL_MUL;
               default: dec_ctrl = CTL_ILL;
            endcase
         end
         OP_ADDI:  dec_ctrl = CTL_ADDU;
         OP_SLTIU: dec_ctrl = CTL_SLTU;
         OP_BEQ:   dec_ctrl = CTL_SUBU;
         OP_BNE:   dec_ctrl = CTL_SUBU;
         OP_LUI:   dec_ctrl = CTL_LUI;
         OP_ORI:   dec_ctrl = CTL_OR;
         default:  dec_ctrl = CTL_ILL;
      endcase
   end

   assign dec_is_shift = (dec_ctrl == CTL_SFT) || (dec_ctrl == CTL_SFTV);
   assign dec_amt      = (dec_ctrl == CTL_SFTV) ? src1_i[SH_W-1:0] : shamt_i;
   assign dec_multi    = (dec_ctrl == CTL_MUL) || (dec_is_shift && (dec_amt != '0));

   // Zero-amount shifts land here too and simply pass src2 through.
   always_comb begin
      quick_res = '0;
      case (dec_ctrl)
         CTL_AND:   quick_res = src1_i & src2_i;
         CTL_OR:    quick_res = src1_i | src2_i;
         CTL_NAND:  quick_res = ~(src1_i & src2_i);
         CTL_NOR:   quick_res = ~(src1_i | src2_i);
         CTL_ADDU:  quick_res = src1_i + src2_i;
         CTL_SUBU:  quick_res = src1_i - src2_i;
         CTL_SLT:   quick_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
         CTL_EQUAL: quick_res = {{(DATA_W-1){1'b0}}, (src1_i == src2_i)};
         CTL_SFT:   quick_res = src2_i;
         CTL_SFTV:  quick_res = src2_i;
         CTL_SLTU:  quick_res = {{(DATA_W-1){1'b0}}, (src1_i < src2_i)};
         CTL_LUI:   quick_res = {src2_i[HALF-1:0], {HALF{1'b0}}};
         default:   quick_res = '0;
      endcase
   end

   assign sh_next      = {opb_q[DATA_W-1], opb_q[DATA_W-1:1]};
   assign mul_acc_next = opb_q[0] ? (acc_q + opa_q) : acc_q;

   // Selects what (if anything) the output registers capture on this edge.
   always_comb begin
      fin_load = 1'b0;
      fin_res  = quick_res;
      fin_ctrl = dec_ctrl;
      case (state_q)
         ST_IDLE:  fin_load = valid_i && !dec_multi;
         ST_SHIFT: begin
            fin_load = (count_q == CNT_W'(1));
            fin_res  = sh_next;
            fin_ctrl = ctrl_q;
         end
         ST_MUL: begin
            fin_load = (count_q == CNT_W'(1));
            fin_res  = mul_acc_next;
            fin_ctrl = ctrl_q;
         end
         default:  fin_load = 1'b0;
      endcase
      if (flush_i) fin_load = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         state_q <= ST_IDLE;
         count_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (valid_i) begin
                  ctrl_q <= dec_ctrl;
                  opa_q  <= src1_i;
                  opb_q  <= src2_i;
                  acc_q  <= '0;
                  if (dec_ctrl == CTL_MUL) begin
                     state_q <= ST_MUL;
                     count_q <= CNT_W'(DATA_W);
                  end else if (dec_multi) begin
                     state_q <= ST_SHIFT;
                     count_q <= {1'b0, dec_amt};
                  end else begin
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               opb_q   <= sh_next;
               count_q <= count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) state_q <= ST_DONE;
            end
            ST_MUL: begin
               acc_q   <= mul_acc_next;
               opa_q   <= {opa_q[DATA_W-2:0], 1'b0};
               opb_q   <= {1'b0, opb_q[DATA_W-1:1]};
               count_q <= count_q - CNT_W'(1);
               if (count_q == CNT_W'(1)) state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (ready_i) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         result_o  <= '0;
         zero_o    <= 1'b0;
         ALUCtrl_o <= '0;
         illegal_o <= 1'b0;
      end else if (fin_load) begin
         result_o  <= fin_res;
         zero_o    <= (fin_res == '0);
         ALUCtrl_o <= fin_ctrl;
         illegal_o <= (fin_ctrl == CTL_ILL);
      end
   end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: directed plan items plus random ops, with
// expected results queued at accept time and compared at the result handshake.
module tb_alu_exec_seq;

   localparam int W = 32;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         flush_i;
   logic         valid_i;
   logic         ready_o;
   logic [2:0]   ALUOp_i;
   logic [5:0]   funct_i;
   logic [4:0]   shamt_i;
   logic [W-1:0] src1_i;
   logic [W-1:0] src2_i;
   logic         valid_o;
   logic         ready_i;
   logic [W-1:0] result_o;
   logic         zero_o;
   logic [3:0]   ALUCtrl_o;
   logic         illegal_o;
   logic [1:0]   state_o;

   logic [W-1:0] exp_q[$];
   logic [3:0]   ctrl_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   alu_exec_seq #(.DATA_W(W), .SH_W(5), .FUNCT_W(6), .OP_W(3)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
      .ready_o(ready_o), .ALUOp_i(ALUOp_i), .funct_i(funct_i), .shamt_i(shamt_i),
      .src1_i(src1_i), .src2_i(src2_i), .valid_o(valid_o), .ready_i(ready_i),
      .result_o(result_o), .zero_o(zero_o), .ALUCtrl_o(ALUCtrl_o),
      .illegal_o(illegal_o), .state_o(state_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: result, control code and accept-to-valid latency.
   task automatic model(input logic [2:0] op, input logic [5:0] funct, input logic [4:0] shamt,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic [3:0] ctrl, output int lat);
      res = 0; ctrl = 4'd15; lat = 1;
      case (op)
         3'd0: case (funct)
            6'b100001: begin ctrl = 4; res = a + b; end
            6'b100011: begin ctrl = 5; res = a - b; end
            6'b100100: begin ctrl = 0; res = a & b; end
            6'b100101: begin ctrl = 1; res = a | b; end
            6'b101010: begin ctrl = 6; res = ($signed(a) < $signed(b)) ? 1 : 0; end
            6'b000011: begin ctrl = 8; res = W'($signed(b) >>> shamt); lat = 1 + int'(shamt); end
            6'b000111: begin ctrl = 9; res = W'($signed(b) >>> a[4:0]); lat = 1 + int'(a[4:0]); end
            6'b011000: begin ctrl = 12; res = a * b; lat = W + 1; end
            default:   begin ctrl = 15; res = 0; end
         endcase
         3'd1: begin ctrl = 4; res = a + b; end
         3'd2: begin ctrl = 10; res = (a < b) ? 1 : 0; end
         3'd3, 3'd6: begin ctrl = 5; res = a - b; end
         3'd4: begin ctrl = 11; res = {b[15:0], 16'h0000}; end
         3'd5: begin ctrl = 1; res = a | b; end
         default: begin ctrl = 15; res = 0; end
      endcase
   endtask

   // Presents an op and returns just after the edge that accepted it.
   task automatic drive_op(input logic [2:0] op, input logic [5:0] funct, input logic [4:0] shamt,
                           input logic [W-1:0] a, input logic [W-1:0] b);
      bit accepted = 0;
      @(posedge clk_i); #1;
      valid_i = 1; ALUOp_i = op; funct_i = funct; shamt_i = shamt; src1_i = a; src2_i = b;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk_i);
         if (ready_o) accepted = 1;
         @(posedge clk_i); #1;
      end
      valid_i = 0;
      if (!accepted) check("accept_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [5:0] funct, input logic [4:0] shamt,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      logic [W-1:0] res;
      logic [3:0]   ctrl;
      int           exp_lat;
      int           lat;
      model(op, funct, shamt, a, b, res, ctrl, exp_lat);
      if (hold > 0) ready_i = 0;
      exp_q.push_back(res);
      ctrl_q.push_back(ctrl);
      drive_op(op, funct, shamt, a, b);
      lat = 1;
      while (lat < 100) begin
         @(negedge clk_i);
         if (valid_o) break;
         @(posedge clk_i); #1;
         lat++;
      end
      check("latency", W'(lat), W'(exp_lat));
      if (hold > 0) begin
         repeat (hold) @(posedge clk_i);
         #1 ready_i = 1;
      end
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         @(posedge clk_i); #1;
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", W'(exp_q.size()), 0);
         exp_q.delete();
         ctrl_q.delete();
      end
   endtask

   // Scoreboard: held result must match the queue head every cycle valid_o is up.
   always @(negedge clk_i) begin
      if (rst_i === 1'b1 && valid_o) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", 1, 0);
         end else begin
            check("result", result_o, exp_q[0]);
            check("ctrl", W'(ALUCtrl_o), W'(ctrl_q[0]));
            check("illegal", W'(illegal_o), W'(ctrl_q[0] == 4'd15));
            check("zero", W'(zero_o), W'(exp_q[0] == 0));
            check("ready_busy", W'(ready_o), 0);
            if (ready_i) begin
               void'(exp_q.pop_front());
               void'(ctrl_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [5:0] fn_tab[9];
      logic [2:0] op;
      logic [5:0] fn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      fn_tab = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010,
                 6'b000011, 6'b000111, 6'b011000, 6'b110011};

      rst_i = 0; flush_i = 0; valid_i = 0; ready_i = 1;
      ALUOp_i = 0; funct_i = 0; shamt_i = 0; src1_i = 0; src2_i = 0;
      #12;
      check("rst_valid", W'(valid_o), 0);
      check("rst_result", result_o, 0);
      check("rst_ctrl", W'(ALUCtrl_o), 0);
      check("rst_illegal", W'(illegal_o), 0);
      check("rst_zero", W'(zero_o), 0);
      check("rst_state", W'(state_o), 0);
      @(negedge clk_i); rst_i = 1;
      @(negedge clk_i);
      check("rst_ready", W'(ready_o), 1);

      run_op(3'd0, 6'b100001, 0, 5, 7, 0);
      check("addu_res", result_o, 12);
      check("addu_ctrl", W'(ALUCtrl_o), 4);
      run_op(3'd3, 0, 0, 9, 9, 0);
      check("beq_zero", W'(zero_o), 1);
      check("beq_ctrl", W'(ALUCtrl_o), 5);
      run_op(3'd0, 6'b100011, 0, 3, 5, 0);
      check("subu_res", result_o, 32'hFFFF_FFFE);
      run_op(3'd0, 6'b000111, 0, 4, 32'h8000_0000, 0);
      check("sftv_res", result_o, 32'hF800_0000);
      run_op(3'd0, 6'b000011, 0, 32'h1F, 32'h1234_5678, 0);
      check("sft0_res", result_o, 32'h1234_5678);
      run_op(3'd0, 6'b011000, 0, 32'h1234, 32'h10, 3);
      check("mul_res", result_o, 32'h0001_2340);
      check("mul_idle", W'(state_o), 0);
      run_op(3'd0, 6'b111111, 0, 32'hDEAD, 32'hBEEF, 0);
      check("ill_funct", W'(illegal_o), 1);
      run_op(3'd7, 0, 0, 32'h1, 32'h2, 0);
      check("ill_op_res", result_o, 0);
      run_op(3'd4, 0, 0, 0, 32'hABCD_8765, 0);
      check("lui_res", result_o, 32'h8765_0000);

      // Flush ten cycles into a multiply: nothing may come out.
      drive_op(3'd0, 6'b011000, 0, 32'h3, 32'h5);
      repeat (10) @(posedge clk_i);
      #1 flush_i = 1;
      @(posedge clk_i); #1 flush_i = 0;
      @(negedge clk_i);
      check("flush_valid", W'(valid_o), 0);
      check("flush_ready", W'(ready_o), 1);
      check("flush_state", W'(state_o), 0);
      repeat (40) @(posedge clk_i);

      // Flush in IDLE blocks the accept.
      #1 flush_i = 1; valid_i = 1; ALUOp_i = 3'd1;
      @(negedge clk_i);
      check("flush_idle_ready", W'(ready_o), 0);
      @(posedge clk_i); #1 flush_i = 0; valid_i = 0;
      @(negedge clk_i);
      check("flush_idle_state", W'(state_o), 0);

      // Asynchronous reset in the middle of a 20-bit shift.
      drive_op(3'd0, 6'b000111, 0, 20, 32'h8000_0000);
      repeat (5) @(posedge clk_i);
      #3 rst_i = 0;
      #2;
      check("midrst_state", W'(state_o), 0);
      check("midrst_valid", W'(valid_o), 0);
      @(negedge clk_i); rst_i = 1;
      @(negedge clk_i);
      check("midrst_ready", W'(ready_o), 1);
      repeat (30) @(posedge clk_i);
      run_op(3'd1, 0, 0, 1, 1, 0);
      check("addi_res", result_o, 2);

      for (int k = 0; k < 24; k++) begin
         op = 3'($urandom_range(0, 7));
         fn = fn_tab[$urandom_range(0, 8)];
         a = $urandom();
         b = $urandom();
         run_op(op, fn, 5'($urandom_range(0, 31)), a, b, $urandom_range(0, 2));
      end

      repeat (5) @(posedge clk_i);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
